// File: rtl/sys_bus_burst_ctrl_pkg.sv
// Shared types and default parameters for the burst bus master.
// State encodings are one-hot so each state maps to a single flop.
package sys_bus_burst_ctrl_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int LEN_W_DEF   = 2;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_ALEN = 5'b00010,
    ST_XFER = 5'b00100,
    ST_COMP = 5'b01000,
    ST_ERR  = 5'b10000
  } state_e;

endpackage

// File: rtl/sys_bus_burst_ctrl_if.sv
// Requester, write-beat, read-beat and slave-bus signals of the burst master.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// bus enables are held until bus_ack is sampled high on a rising edge.
interface sys_bus_burst_ctrl_if
  import sys_bus_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_read_en;
  logic              bus_write_en;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  state_e            dbg_state;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid, bus_rdata, bus_ack,
    output req_ready, wr_ready, rd_data, rd_valid, done, err, busy,
           bus_addr, bus_read_en, bus_write_en, bus_wdata, dbg_state
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid, bus_rdata, bus_ack,
    input  req_ready, wr_ready, rd_data, rd_valid, done, err, busy,
           bus_addr, bus_read_en, bus_write_en, bus_wdata, dbg_state
  );

endinterface

// File: rtl/sys_bus_beat_timer.sv
// Counts consecutive strobe cycles without ack; expired_o flags the last
// permitted cycle so the controller can drop the strobe on that same edge.
module sys_bus_beat_timer
  import sys_bus_burst_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // An ack in the final cycle still wins over the timeout.
  assign expired_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sys_bus_burst_ctrl.sv
// Burst bus master: takes 1..2^LEN_W beat read/write requests and walks
// incrementing addresses on the slave port, aborting on an ack timeout.
module sys_bus_burst_ctrl
  import sys_bus_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                  clk,
  input logic                  rst,
  sys_bus_burst_ctrl_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic              dir_q, dir_d, held_q, held_d, rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, wdata_q, wdata_d;
  logic              read_en, write_en, en_any, beat_ack, last_beat, expired;

  assign read_en   = (state_q == ST_XFER) && !dir_q;
  assign write_en  = (state_q == ST_XFER) && dir_q && held_q;
  assign en_any    = read_en || write_en;
  assign beat_ack  = en_any && bus.bus_ack;
  assign last_beat = (cnt_q == len_q);

  sys_bus_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!en_any || beat_ack),
    .enable_i  (en_any),
    .expired_o (expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = ST_ALEN;
          addr_d  = bus.req_addr;
          len_d   = bus.req_len;
          dir_d   = bus.req_write;
          cnt_d   = '0;
          held_d  = 1'b0;
        end
      end
      ST_ALEN: state_d = ST_XFER;
      ST_XFER: begin
        // A write beat is only captured while no beat is pending on the bus.
        if (dir_q && !held_q && bus.wr_valid) begin
          held_d  = 1'b1;
          wdata_d = bus.wr_data;
        end
        if (beat_ack) begin
          held_d = 1'b0;
          if (!dir_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.bus_rdata;
          end
          if (last_beat) begin
            state_d = ST_COMP;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q + LEN_W'(1);
          end
        end else if (expired) begin
          state_d = ST_ERR;
          held_d  = 1'b0;
        end
      end
      ST_COMP, ST_ERR: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset drops an in-flight burst without any done/err pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      held_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.wr_ready     = (state_q == ST_XFER) && dir_q && !held_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.done         = (state_q == ST_COMP) || (state_q == ST_ERR);
  assign bus.err          = (state_q == ST_ERR);
  assign bus.bus_addr     = addr_q;
  assign bus.bus_read_en  = read_en;
  assign bus.bus_write_en = write_en;
  assign bus.bus_wdata    = wdata_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_sys_bus_burst_ctrl.sv
// Bench for sys_bus_burst_ctrl: directed and random bursts against a
// behavioural slave memory and per-burst expected address/data queues.
module tb_sys_bus_burst_ctrl;
  import sys_bus_burst_ctrl_pkg::*;

  localparam int TIMEOUT = TIMEOUT_DEF;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] mem [256];

  sys_bus_burst_ctrl_if bus ();

  sys_bus_burst_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.bus_ack   = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_ctl", {bus.bus_read_en, bus.bus_write_en, bus.rd_valid, bus.done, bus.err, bus.wr_ready}, 0);
    check("rst_addr", bus.bus_addr, 0);
    check("rst_rdata", bus.rd_data, 0);
    check("rst_wdata", bus.bus_wdata, 0);
    rst = 1'b1;
  endtask

  // driver + slave model for one burst
  task automatic run_burst(input bit wr, input logic [7:0] addr, input logic [1:0] len,
                           input int ws, input int gap, input bit no_ack, input bit hold_req,
                           input int abort_beat, input bit use_fixed, input logic [31:0] wd_fixed,
                           input bit lat_check);
    logic [7:0] exp_addr_q[$];
    logic [7:0] exp_wd_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] a, d;
    int beats, beat, wait_cnt, en_cycles, gap_cnt, first_en_cyc, done_cyc;
    bit finished, bad_ready, bad_busy, bad_en;
    beats = int'(len) + 1;
    beat = 0; wait_cnt = 0; en_cycles = 0; gap_cnt = 0;
    first_en_cyc = -1; done_cyc = -1;
    finished = 0; bad_ready = 0; bad_busy = 0; bad_en = 0;
    for (int i = 0; i < beats; i++) begin
      a = addr + 8'(i);
      exp_addr_q.push_back(a);
      if (wr) begin
        d = use_fixed ? wd_fixed[8*i +: 8] : 8'($urandom);
        wd_q.push_back(d);
        exp_wd_q.push_back(d);
      end else begin
        exp_rd_q.push_back(mem[a]);
      end
    end

    @(negedge clk);
    check("ready_before", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.bus_ack   = 1'b0;
    bus.wr_valid  = 1'b0;

    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clk);
      if (!hold_req) bus.req_valid = 1'b0;
      if (bus.req_ready) bad_ready = 1;
      if (bus.busy !== ~bus.req_ready) bad_busy = 1;
      if (bus.bus_read_en && bus.bus_write_en) bad_en = 1;
      if (wr ? bus.bus_read_en : bus.bus_write_en) bad_en = 1;
      if (cyc == 1) begin
        check("alen_addr", bus.bus_addr, addr);
        check("alen_en", {bus.bus_read_en, bus.bus_write_en}, 0);
      end
      if (bus.rd_valid) begin
        if (exp_rd_q.size() > 0) check("rd_data", bus.rd_data, exp_rd_q.pop_front());
        else check("rd_valid_extra", bus.rd_valid, 0);
      end
      if (bus.done) begin
        done_cyc = cyc;
        finished = 1;
        check("err", bus.err, no_ack);
        check("done_en", {bus.bus_read_en, bus.bus_write_en}, 0);
        if (!no_ack && !wr) check("done_rdv", bus.rd_valid, 1);
        check("beats", beat, no_ack ? 0 : beats);
        if (no_ack) check("to_cycles", en_cycles, TIMEOUT);
        bus.req_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.bus_ack   = 1'b0;
      end else if (abort_beat >= 0 && beat == abort_beat &&
                   (bus.bus_read_en || bus.bus_write_en)) begin
        rst = 1'b0;
        bus.bus_ack   = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_ctl", {bus.bus_read_en, bus.bus_write_en, bus.done, bus.err, bus.rd_valid}, 0);
        check("abort_ready", bus.req_ready, 1);
        rst = 1'b1;
        return;
      end else begin
        if (bus.bus_read_en || bus.bus_write_en) begin
          en_cycles++;
          if (first_en_cyc < 0) first_en_cyc = cyc;
          if (!no_ack && wait_cnt == ws) begin
            bus.bus_ack = 1'b1;
            if (exp_addr_q.size() > 0) check("addr", bus.bus_addr, exp_addr_q.pop_front());
            else check("beat_extra", beat, beats - 1);
            if (wr) begin
              if (exp_wd_q.size() > 0) check("wdata", bus.bus_wdata, exp_wd_q.pop_front());
              mem[bus.bus_addr] = bus.bus_wdata;
            end else begin
              bus.bus_rdata = mem[bus.bus_addr];
            end
            check("en_cycles", en_cycles, ws + 1);
            en_cycles = 0;
            wait_cnt  = 0;
            beat++;
          end else begin
            bus.bus_ack   = 1'b0;
            bus.bus_rdata = 8'($urandom);
            wait_cnt++;
          end
        end else begin
          // ack noise while no strobe is up must be ignored
          bus.bus_ack   = 1'($urandom_range(0, 1));
          bus.bus_rdata = 8'($urandom);
        end
        if (wr && bus.wr_ready && wd_q.size() > 0) begin
          if (gap_cnt >= gap) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wd_q.pop_front();
            gap_cnt = 0;
          end else begin
            bus.wr_valid = 1'b0;
            gap_cnt++;
          end
        end else begin
          bus.wr_valid = 1'b0;
        end
      end
    end

    check("finished", finished, 1);
    check("ready_during", bad_ready, 0);
    check("busy_vs_ready", bad_busy, 0);
    check("enable_sel", bad_en, 0);
    if (!wr && !no_ack) check("rd_left", exp_rd_q.size(), 0);
    if (lat_check) begin
      check("lat_en", first_en_cyc, 2);
      check("lat_done", done_cyc, 3);
    end
    bus.bus_ack = 1'b0;
    @(negedge clk);
    check("ready_after", bus.req_ready, 1);
    check("done_once", bus.done, 0);
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.bus_rdata = '0;
    bus.bus_ack   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    do_reset(2);

    // single read, zero wait states, latency
    mem[8'h10] = 8'hA5;
    run_burst(1'b0, 8'h10, 2'd0, 0, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, 1'b1);

    // 4-beat write across the address wrap, 2 wait states per beat
    run_burst(1'b1, 8'hFE, 2'd3, 2, 0, 1'b0, 1'b0, -1, 1'b1, 32'h44332211, 1'b0);
    check("mem_wrap_ff", mem[8'hFF], 8'h22);
    check("mem_wrap_00", mem[8'h00], 8'h33);

    // reset mid-idle clears data registers
    do_reset(2);

    // ack timeout
    run_burst(1'b0, 8'h20, 2'd2, 0, 0, 1'b1, 1'b0, -1, 1'b0, 32'h0, 1'b0);

    // reset during beat 2 of a 4-beat read, then a clean read
    run_burst(1'b0, 8'h40, 2'd3, 1, 0, 1'b0, 1'b0, 1, 1'b0, 32'h0, 1'b0);
    run_burst(1'b0, 8'h30, 2'd0, 0, 0, 1'b0, 1'b0, -1, 1'b0, 32'h0, 1'b0);

    // request held through a write burst with 5-cycle data gaps
    run_burst(1'b1, 8'h50, 2'd3, 1, 5, 1'b0, 1'b1, -1, 1'b0, 32'h0, 1'b0);

    // random bursts
    for (int n = 0; n < 16; n++) begin
      run_burst(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)),
                -1, 1'b0, 32'h0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
